// File: rtl/seg7_pkg.sv
// Shared definitions for seven-segment display blocks: blanking constants,
// active-low hex glyph table and scan controller state type.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode display scanner with per-slot blanking and
// frame-synchronous update of the displayed value.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_mask_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  sel,
  output logic        frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    sel_n;
  logic [15:0]   pend_d, act_d, act_d_n;
  logic [3:0]    pend_dp, act_dp, act_dp_n;

  logic [3:0]    nib;
  logic [6:0]    seg_dec;
  logic          scanning, slot_end, lit;
  logic [3:0]    an_n;
  logic [6:0]    seg_n;
  logic          dp_n, tick_n;

  hex_to_seg7 u_dec (
    .hex (nib),
    .seg (seg_dec)
  );

  always_comb begin
    nib      = act_d[{sel, 2'b00} +: 4];
    scanning = (state == SCAN) && en;
    slot_end = (cnt == CNT_LAST);
    lit      = scanning && (int'(cnt) >= BLANK);

    state_n  = state;
    cnt_n    = cnt;
    sel_n    = sel;
    act_d_n  = act_d;
    act_dp_n = act_dp;
    tick_n   = 1'b0;

    case (state)
      IDLE: begin
        cnt_n    = '0;
        sel_n    = '0;
        act_d_n  = pend_d;
        act_dp_n = pend_dp;
        if (en) state_n = SCAN;
      end
      SCAN: begin
        if (!en) begin
          state_n = IDLE;
          cnt_n   = '0;
          sel_n   = '0;
        end else if (slot_end) begin
          cnt_n = '0;
          sel_n = sel + 2'd1;
          // Frame boundary: commit pending data; a coincident load lands in pending
          if (sel == 2'd3) begin
            act_d_n  = pend_d;
            act_dp_n = pend_dp;
            tick_n   = 1'b1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    an_n  = lit ? ~(4'b0001 << sel) : AN_OFF;
    seg_n = lit ? seg_dec : SEG_OFF;
    dp_n  = lit ? ~act_dp[sel] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      sel        <= '0;
      pend_d     <= '0;
      pend_dp    <= '0;
      act_d      <= '0;
      act_dp     <= '0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      sel        <= sel_n;
      act_d      <= act_d_n;
      act_dp     <= act_dp_n;
      an         <= an_n;
      seg        <= seg_n;
      dp         <= dp_n;
      frame_tick <= tick_n;
      if (load) begin
        pend_d  <= digits_in;
        pend_dp <= dp_mask_in;
      end
    end
  end

endmodule
